// File: rtl/button_repeat_ctrl_pkg.sv
// Shared definitions for the clock-adjust button conditioner: FSM state
// encoding and default timing derived from the 32768 Hz system clock.
package button_repeat_ctrl_pkg;

    localparam int SYS_CLK_HZ = 32768;

    // 1/128 s debounce, 0.5 s hold-off, ~0.2 s repeat period.
    localparam int DEF_DEBOUNCE_CYCLES = SYS_CLK_HZ / 128;
    localparam int DEF_HOLD_CYCLES     = SYS_CLK_HZ / 2;
    localparam int DEF_REPEAT_CYCLES   = (SYS_CLK_HZ * 2 + 5) / 10;
    localparam int DEF_CNT_W           = 16;

    typedef logic [2:0] btn_state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DB_PRESS = 3'd1;
    localparam logic [2:0] ST_HOLD     = 3'd2;
    localparam logic [2:0] ST_REPEAT   = 3'd3;
    localparam logic [2:0] ST_DB_REL   = 3'd4;

    // A button counts as held from the accepted press until the release is accepted.
    function automatic logic is_held_state(input btn_state_t s);
        logic r;
        case (s)
            ST_HOLD, ST_REPEAT, ST_DB_REL: r = 1'b1;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/button_repeat_ctrl_if.sv
// Button pads in, step/held/combo requests out towards the clock core.
interface button_repeat_ctrl_if;
    import button_repeat_ctrl_pkg::*;

    logic [1:0] i_btn_n;
    logic [1:0] o_step;
    logic [1:0] o_held;
    logic       o_combo_pulse;

    modport master (
        output i_btn_n,
        input  o_step,
        input  o_held,
        input  o_combo_pulse
    );

    modport slave (
        input  i_btn_n,
        output o_step,
        output o_held,
        output o_combo_pulse
    );

endinterface

// File: rtl/button_repeat_ctrl_btn_channel.sv
// One button: 2-FF synchroniser, debounce/hold/repeat FSM and its counter.
// Exposes next-cycle step/held so the top can register masked outputs.
module btn_channel
    import button_repeat_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_n,
    output logic o_step_nxt,
    output logic o_held_nxt
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       r_sync;
    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pressed;
    logic             w_step_nxt;

    // Pads idle high, so the synchroniser resets to the released level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_btn_n};
        end
    end

    assign w_pressed = ~r_sync[1];

    // Next-state/counter logic; release always takes priority over a due step.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_ONE;
        w_step_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = CNT_ZERO;
                if (w_pressed) begin
                    w_state_nxt = ST_DB_PRESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DB_PRESS: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = CNT_ZERO;
                    w_step_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_DB_PRESS;
                end
            end
            ST_HOLD: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_DB_REL;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_REPEAT;
                    w_cnt_nxt   = CNT_ZERO;
                    w_step_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_REPEAT: begin
                if (!w_pressed) begin
                    w_state_nxt = ST_DB_REL;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == REP_LAST) begin
                    w_cnt_nxt   = CNT_ZERO;
                    w_step_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_REPEAT;
                end
            end
            ST_DB_REL: begin
                // Any pressed sample restarts the release window.
                if (w_pressed) begin
                    w_cnt_nxt = CNT_ZERO;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end else begin
                    w_state_nxt = ST_DB_REL;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
    end

    // FSM state and dwell counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign o_step_nxt = w_step_nxt;
    assign o_held_nxt = is_held_state(w_state_nxt);

endmodule

// File: rtl/button_repeat_ctrl.sv
// Minutes/hours button conditioner: two independent channels plus the
// both-held step masking and combo pulse.
module button_repeat_ctrl
    import button_repeat_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    button_repeat_ctrl_if.slave  bus
);

    logic [1:0] w_step_nxt;
    logic [1:0] w_held_nxt;
    logic       w_both_nxt;
    logic       w_both;
    logic [1:0] r_step;
    logic [1:0] r_held;
    logic       r_both_d;
    logic       r_combo;

    for (genvar g = 0; g < 2; g++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .i_btn_n    (bus.i_btn_n[g]),
            .o_step_nxt (w_step_nxt[g]),
            .o_held_nxt (w_held_nxt[g])
        );
    end

    assign w_both_nxt = w_held_nxt[0] & w_held_nxt[1];
    assign w_both     = r_held[0] & r_held[1];

    // Masking uses the same-cycle held value, so the second button's own
    // press step is suppressed as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step   <= 2'b00;
            r_held   <= 2'b00;
            r_both_d <= 1'b0;
            r_combo  <= 1'b0;
        end else begin
            r_step   <= w_step_nxt & ~{2{w_both_nxt}};
            r_held   <= w_held_nxt;
            r_both_d <= w_both;
            r_combo  <= w_both & ~r_both_d;
        end
    end

    assign bus.o_step        = r_step;
    assign bus.o_held        = r_held;
    assign bus.o_combo_pulse = r_combo;

endmodule

// File: tb/tb_button_repeat_ctrl.sv
// Directed bench for button_repeat_ctrl with short timing (4/20/8): per-edge
// output traces are compared against hand-derived expected masks.
module tb_button_repeat_ctrl;

    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 8;
    localparam int N = 128;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    button_repeat_ctrl_if bus ();

    button_repeat_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R),
        .CNT_W           (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [N-1:0] low0;
        logic [N-1:0] low1;
        logic [N-1:0] rst;
        logic [N-1:0] e_s0;
        logic [N-1:0] e_s1;
        logic [N-1:0] e_h0;
        logic [N-1:0] e_h1;
        logic [N-1:0] e_c;
    } vec_t;

    vec_t tv [10];

    function automatic logic [N-1:0] rng(input int lo, input int hi);
        logic [N-1:0] m;
        m = '0;
        for (int i = lo; i < hi; i++) begin
            if (i >= 0 && i < N) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [N-1:0] bit_at(input int e);
        return rng(e, e + 1);
    endfunction

    task automatic cmp_mask(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
        int first;
        checks++;
        if (got !== exp) begin
            failures++;
            first = -1;
            for (int i = N - 1; i >= 0; i--) begin
                if (got[i] !== exp[i]) first = i;
            end
            $display("FAIL %s: first diff at edge %0d, got=%h want=%h", nm, first, got, exp);
        end
    endtask

    task automatic cmp_val(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got=%0d want=%0d", nm, got, exp);
        end
    endtask

    // Leaves the bench at a falling edge with reset released and buttons up.
    task automatic do_reset();
        reset = 1'b1;
        bus.i_btn_n = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input int k);
        logic [N-1:0] g_s0, g_s1, g_h0, g_h1, g_c;
        g_s0 = '0; g_s1 = '0; g_h0 = '0; g_h1 = '0; g_c = '0;
        for (int e = 0; e < N; e++) begin
            bus.i_btn_n = {~tv[k].low1[e], ~tv[k].low0[e]};
            reset       = tv[k].rst[e];
            @(posedge clk);
            @(negedge clk);
            g_s0[e] = bus.o_step[0];
            g_s1[e] = bus.o_step[1];
            g_h0[e] = bus.o_held[0];
            g_h1[e] = bus.o_held[1];
            g_c[e]  = bus.o_combo_pulse;
        end
        reset = 1'b0;
        cmp_mask({tv[k].name, ".step0"}, g_s0, tv[k].e_s0);
        cmp_mask({tv[k].name, ".step1"}, g_s1, tv[k].e_s1);
        cmp_mask({tv[k].name, ".held0"}, g_h0, tv[k].e_h0);
        cmp_mask({tv[k].name, ".held1"}, g_h1, tv[k].e_h1);
        cmp_mask({tv[k].name, ".combo"}, g_c,  tv[k].e_c);
    endtask

    initial begin
        int first_step;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.i_btn_n = 2'b11;

        for (int k = 0; k < 10; k++) begin
            tv[k].name = "";
            tv[k].low0 = '0; tv[k].low1 = '0; tv[k].rst = '0;
            tv[k].e_s0 = '0; tv[k].e_s1 = '0; tv[k].e_h0 = '0;
            tv[k].e_h1 = '0; tv[k].e_c  = '0;
        end

        tv[0].name = "press10";
        tv[0].low0 = rng(0, 10);
        tv[0].e_s0 = bit_at(6);
        tv[0].e_h0 = rng(6, 16);

        tv[1].name = "bounce1";
        for (int k = 0; k < 5; k++) tv[1].low1 |= rng(6 * k, 6 * k + 3);

        tv[2].name = "hold70";
        tv[2].low0 = rng(0, 70);
        tv[2].e_s0 = bit_at(6) | bit_at(26) | bit_at(34) | bit_at(42)
                   | bit_at(50) | bit_at(58) | bit_at(66);
        tv[2].e_h0 = rng(6, 76);

        tv[3].name = "combo";
        tv[3].low0 = rng(0, 80);
        tv[3].low1 = rng(12, 40);
        tv[3].e_s0 = bit_at(6) | bit_at(50) | bit_at(58) | bit_at(66) | bit_at(74);
        tv[3].e_h0 = rng(6, 86);
        tv[3].e_h1 = rng(18, 46);
        tv[3].e_c  = bit_at(19);

        tv[4].name = "reset_hold";
        tv[4].low0 = rng(0, 30);
        tv[4].rst  = bit_at(15);
        tv[4].e_s0 = bit_at(6) | bit_at(22);
        tv[4].e_h0 = rng(6, 15) | rng(22, 36);

        tv[5].name = "rel_glitch";
        tv[5].low0 = rng(0, 10) | rng(13, 15);
        tv[5].e_s0 = bit_at(6);
        tv[5].e_h0 = rng(6, 20);

        tv[6].name = "press_short";
        tv[6].low0 = rng(0, D);

        tv[7].name = "press_min";
        tv[7].low0 = rng(0, D + 1);
        tv[7].e_s0 = bit_at(6);
        tv[7].e_h0 = rng(6, 11);

        tv[8].name = "both_same";
        tv[8].low0 = rng(0, 10);
        tv[8].low1 = rng(0, 10);
        tv[8].e_h0 = rng(6, 16);
        tv[8].e_h1 = rng(6, 16);
        tv[8].e_c  = bit_at(7);

        tv[9].name = "combo_rearm";
        tv[9].low0 = rng(0, 60);
        tv[9].low1 = rng(0, 10) | rng(30, 50);
        tv[9].e_s0 = bit_at(26) | bit_at(34) | bit_at(58);
        tv[9].e_h0 = rng(6, 66);
        tv[9].e_h1 = rng(6, 16) | rng(36, 56);
        tv[9].e_c  = bit_at(7) | bit_at(37);

        do_reset();
        cmp_val("reset.step",  int'(bus.o_step), 0);
        cmp_val("reset.held",  int'(bus.o_held), 0);
        cmp_val("reset.combo", int'(bus.o_combo_pulse), 0);

        for (int k = 0; k < 10; k++) begin
            do_reset();
            run_vec(k);
        end

        // Reset held for two cycles mid-press, then re-debounce from scratch.
        do_reset();
        bus.i_btn_n = 2'b10;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
        end
        cmp_val("midrst.held_before", int'(bus.o_held), 1);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            cmp_val("midrst.outs_in_reset",
                    int'({bus.o_step, bus.o_held, bus.o_combo_pulse}), 0);
        end
        reset = 1'b0;
        first_step = -1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.o_step[0] && first_step < 0) first_step = e;
        end
        cmp_val("midrst.first_step_edge", first_step, D + 2);

        bus.i_btn_n = 2'b11;
        repeat (20) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
